writeback_arbiter: RTL and testbench

Drives the register file's single write port (write index, write content, write flag) from two result producers: the single-cycle ALU path and the multi-cycle memory/load path. ALU results are accepted directly. Memory results are buffered in a small FIFO. Conflicts between the two are resolved by alternating priority. The block also keeps a pending-write scoreboard that the issue stage sets on dispatch and queries for read-after-write hazards.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/writeback_arbiter.sv | 145 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the writeback path.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // One pending register-file write: destination index plus result data.
    typedef struct packed {
        logic [REG_AW-1:0] index;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests with a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t pop_req,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_req_t          slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign pop_req = slots_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            slots_q[wr_ptr_q] <= push_req;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results go straight through, memory
// results are buffered, conflicts alternate priority, and a pending-write
// scoreboard answers read-after-write hazard queries.
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_index,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_index,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              claim_valid,
    input  logic [REG_AW-1:0] claim_index,
    input  logic [REG_AW-1:0] check_index1,
    input  logic [REG_AW-1:0] check_index2,
    output logic              busy1,
    output logic              busy2,
    output logic              wr_flag,
    output logic [REG_AW-1:0] wr_index,
    output logic [DATA_W-1:0] wr_content
);

    import cpu_pkg::*;

    localparam int NUM_REGS = 2 ** REG_AW;

    wb_req_t           mem_req;
    wb_req_t           head_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_valid;
    logic              conflict;
    logic              alu_grant;
    logic              mem_grant;
    logic              prio_mem_q, prio_mem_d;
    logic              wr_flag_q, wr_flag_d;
    logic [REG_AW-1:0] wr_index_q, wr_index_d;
    logic [DATA_W-1:0] wr_content_q, wr_content_d;
    logic [NUM_REGS-1:0] busy_vec;

    // Ready depends only on registered occupancy, never on the ALU side.
    assign mem_ready = !fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (mem_valid && mem_ready),
        .push_req (mem_req),
        .pop      (mem_grant),
        .pop_req  (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Arbitration between ALU and FIFO head, and next write-port contents.
    always_comb begin
        mem_req.index = mem_index;
        mem_req.data  = mem_data;
        head_valid    = !fifo_empty;
        conflict      = alu_valid && head_valid;
        alu_grant     = alu_valid && (!head_valid || !prio_mem_q);
        mem_grant     = head_valid && (!alu_valid || prio_mem_q);
        prio_mem_d    = prio_mem_q ^ conflict;
        wr_flag_d     = 1'b0;
        wr_index_d    = wr_index_q;
        wr_content_d  = wr_content_q;
        if (alu_grant) begin
            wr_flag_d    = (alu_index != REG_ZERO);
            wr_index_d   = alu_index;
            wr_content_d = alu_data;
        end else if (mem_grant) begin
            wr_flag_d    = (head_req.index != REG_ZERO);
            wr_index_d   = head_req.index;
            wr_content_d = head_req.data;
        end
    end

    assign alu_ready = alu_grant;

    // Write port register and priority flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_mem_q   <= 1'b0;
            wr_flag_q    <= 1'b0;
            wr_index_q   <= '0;
            wr_content_q <= '0;
        end else begin
            prio_mem_q   <= prio_mem_d;
            wr_flag_q    <= wr_flag_d;
            wr_index_q   <= wr_index_d;
            wr_content_q <= wr_content_d;
        end
    end

    assign wr_flag    = wr_flag_q;
    assign wr_index   = wr_index_q;
    assign wr_content = wr_content_q;

    // Scoreboard: one busy bit per register, register zero never pending.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
            end else begin : g_bit
                logic busy_q, busy_d;

                // Claim sets, the committed write clears; a same-cycle claim wins.
                always_comb begin
                    busy_d = busy_q;
                    if (wr_flag_q && (wr_index_q == REG_AW'(gi))) begin
                        busy_d = 1'b0;
                    end
                    if (claim_valid && (claim_index == REG_AW'(gi))) begin
                        busy_d = 1'b1;
                    end
                end

                // Busy bit register.
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        busy_q <= 1'b0;
                    end else begin
                        busy_q <= busy_d;
                    end
                end

                assign busy_vec[gi] = busy_q;
            end
        end
    endgenerate

    assign busy1 = busy_vec[check_index1];
    assign busy2 = busy_vec[check_index2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_index;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_index;
    logic [31:0] mem_data;
    logic        claim_valid;
    logic [4:0]  claim_index;
    logic [4:0]  check_index1, check_index2;
    logic        busy1, busy2;
    logic        wr_flag;
    logic [4:0]  wr_index;
    logic [31:0] wr_content;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] dat;
    } item_t;

    item_t alu_q[$];
    item_t mem_q[$];
    item_t log_q[$];
    int    stall_cycle;
    int    rise_cycle;

    logic [4:0] order_conflict [8]  = '{5'd1, 5'd8, 5'd2, 5'd9, 5'd3, 5'd10, 5'd4, 5'd11};
    logic [4:0] order_full     [16] = '{5'd12, 5'd13, 5'd20, 5'd14, 5'd21, 5'd15, 5'd22, 5'd16,
                                        5'd23, 5'd17, 5'd24, 5'd18, 5'd25, 5'd19, 5'd26, 5'd27};

    always #5 clock = ~clock;

    writeback_arbiter #(
        .DATA_W     (32),
        .REG_AW     (5),
        .FIFO_DEPTH (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_index    (alu_index),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_index    (mem_index),
        .mem_data     (mem_data),
        .claim_valid  (claim_valid),
        .claim_index  (claim_index),
        .check_index1 (check_index1),
        .check_index2 (check_index2),
        .busy1        (busy1),
        .busy2        (busy2),
        .wr_flag      (wr_flag),
        .wr_index     (wr_index),
        .wr_content   (wr_content)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        claim_valid = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Drives both producers from the queues, logging every committed write.
    task automatic run_traffic(input int alu_start, input int total);
        int c = 0;
        bit a_acc;
        bit m_acc;
        stall_cycle = -1;
        rise_cycle  = -1;
        log_q.delete();
        while (log_q.size() < total && c < 80) begin
            alu_valid = (c >= alu_start) && (alu_q.size() > 0);
            if (alu_q.size() > 0) begin
                alu_index = alu_q[0].idx;
                alu_data  = alu_q[0].dat;
            end
            mem_valid = (mem_q.size() > 0);
            if (mem_q.size() > 0) begin
                mem_index = mem_q[0].idx;
                mem_data  = mem_q[0].dat;
            end
            #1;
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            if (!mem_ready && stall_cycle < 0) stall_cycle = c;
            if (mem_ready && stall_cycle >= 0 && rise_cycle < 0) rise_cycle = c;
            tick();
            if (a_acc) void'(alu_q.pop_front());
            if (m_acc) void'(mem_q.pop_front());
            if (wr_flag) begin
                log_q.push_back('{wr_index, wr_content});
                $display("cycle %0d write r%0d = %h", c, wr_index, wr_content);
            end
            c++;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("traffic_write_count", 64'(log_q.size()), 64'(total));
    endtask

    initial begin
        reset_n      = 1'b1;
        alu_valid    = 1'b0;
        alu_index    = '0;
        alu_data     = '0;
        mem_valid    = 1'b0;
        mem_index    = '0;
        mem_data     = '0;
        claim_valid  = 1'b0;
        claim_index  = '0;
        check_index1 = 5'd5;
        check_index2 = 5'd9;
        #1 reset_n = 1'b0;
        #1;
        // Reset values
        chk("rst_wr_flag", wr_flag, 1'b0);
        chk("rst_wr_index", wr_index, 5'd0);
        chk("rst_wr_content", wr_content, 32'd0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_busy2", busy2, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;

        // Plain ALU write
        alu_valid = 1'b1; alu_index = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_ready_idle", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        $display("alu write: flag=%0b r%0d = %h", wr_flag, wr_index, wr_content);
        chk("alu_wr_flag", wr_flag, 1'b1);
        chk("alu_wr_index", wr_index, 5'd5);
        chk("alu_wr_content", wr_content, 32'hDEADBEEF);
        tick();
        chk("idle_wr_flag", wr_flag, 1'b0);
        chk("idle_hold_index", wr_index, 5'd5);
        chk("idle_hold_content", wr_content, 32'hDEADBEEF);

        // Zero register result is consumed but not written
        alu_valid = 1'b1; alu_index = 5'd0; alu_data = 32'h1234;
        #1;
        chk("zero_alu_ready", alu_ready, 1'b1);
        tick();
        chk("zero_wr_flag", wr_flag, 1'b0);
        chk("zero_wr_content", wr_content, 32'h1234);
        alu_index = 5'd3; alu_data = 32'h33;
        #1;
        chk("after_zero_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        $display("after zero: flag=%0b r%0d = %h", wr_flag, wr_index, wr_content);
        chk("after_zero_wr_flag", wr_flag, 1'b1);
        chk("after_zero_wr_index", wr_index, 5'd3);
        chk("after_zero_wr_content", wr_content, 32'h33);

        // Continuous conflict: memory leads by one cycle so the FIFO head meets r1
        do_reset();
        for (int i = 1; i <= 4; i++) alu_q.push_back('{5'(i), 32'hA000_0000 | i});
        for (int i = 8; i <= 11; i++) mem_q.push_back('{5'(i), 32'hB000_0000 | i});
        run_traffic(1, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("conflict_idx%0d", i), log_q[i].idx, order_conflict[i]);
            chk($sformatf("conflict_dat%0d", i), log_q[i].dat,
                (order_conflict[i] >= 5'd8 ? 32'hB000_0000 : 32'hA000_0000) | 32'(order_conflict[i]));
        end
        chk("conflict_no_stall", 64'(stall_cycle), 64'(-1));
        tick();
        chk("conflict_no_extra_write", wr_flag, 1'b0);

        // FIFO fill with the ALU valid every cycle
        do_reset();
        for (int i = 12; i <= 19; i++) alu_q.push_back('{5'(i), 32'hA000_0000 | i});
        for (int i = 20; i <= 27; i++) mem_q.push_back('{5'(i), 32'hB000_0000 | i});
        run_traffic(0, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_idx%0d", i), log_q[i].idx, order_full[i]);
            chk($sformatf("full_dat%0d", i), log_q[i].dat,
                (order_full[i] >= 5'd20 ? 32'hB000_0000 : 32'hA000_0000) | 32'(order_full[i]));
        end
        chk("full_stall_cycle", 64'(stall_cycle), 64'd6);
        chk("full_ready_rise_cycle", 64'(rise_cycle), 64'd7);

        // Scoreboard: claim, clear after write
        do_reset();
        check_index1 = 5'd7; check_index2 = 5'd0;
        claim_valid = 1'b1; claim_index = 5'd7;
        #1;
        chk("sb_before_claim", busy1, 1'b0);
        tick();
        claim_valid = 1'b0;
        check_index2 = 5'd7;
        #1;
        chk("sb_claimed_busy1", busy1, 1'b1);
        chk("sb_claimed_busy2", busy2, 1'b1);
        alu_valid = 1'b1; alu_index = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        chk("sb_write_flag", wr_flag, 1'b1);
        chk("sb_busy_during_write", busy1, 1'b1);
        tick();
        $display("scoreboard r7 after write: busy1=%0b", busy1);
        chk("sb_cleared", busy1, 1'b0);

        // Claim in the same cycle the register is written: set wins
        claim_valid = 1'b1; claim_index = 5'd7;
        tick();
        claim_valid = 1'b0;
        alu_valid = 1'b1; alu_index = 5'd7; alu_data = 32'h78;
        tick();
        alu_valid = 1'b0;
        chk("sb_same_write_flag", wr_flag, 1'b1);
        claim_valid = 1'b1; claim_index = 5'd7;
        tick();
        claim_valid = 1'b0;
        chk("sb_same_cycle_set_wins", busy1, 1'b1);
        tick();
        chk("sb_still_busy", busy1, 1'b1);

        // Claim of register zero never sets busy
        check_index2 = 5'd0;
        claim_valid = 1'b1; claim_index = 5'd0;
        tick();
        claim_valid = 1'b0;
        chk("sb_r0_never_busy", busy2, 1'b0);

        // Reset in mid-stream with two memory results buffered
        do_reset();
        check_index1 = 5'd3;
        claim_valid = 1'b1; claim_index = 5'd3;
        alu_valid = 1'b1; alu_index = 5'd2; alu_data = 32'h22;
        mem_valid = 1'b1; mem_index = 5'd9; mem_data = 32'h99;
        tick();
        claim_valid = 1'b0;
        alu_index = 5'd4; alu_data = 32'h44;
        mem_index = 5'd10; mem_data = 32'hAA;
        #1;
        chk("mid_alu_ready", alu_ready, 1'b1);
        chk("mid_mem_ready", mem_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("mid_wr_flag", wr_flag, 1'b1);
        chk("mid_busy_r3", busy1, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_wr_flag", wr_flag, 1'b0);
        chk("async_rst_wr_index", wr_index, 5'd0);
        chk("async_rst_mem_ready", mem_ready, 1'b1);
        chk("async_rst_busy", busy1, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_no_write%0d", i), wr_flag, 1'b0);
        end
        chk("post_rst_busy", busy1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
